alu_share_arbiter: RTL and testbench

- Shares one combinational ALU (ADD/SUB/AND/OR/XOR/SLL/SRL/SRA/SLT/SLTU, 4-bit op code) between two requesters, e.g. the integer execute stage and an address/branch helper unit.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Round-robin arbitration; the result is registered with 1-cycle latency and returned to the granted requester.
- The ALU is instantiated outside this block and connected through the alu_* ports.

---
 rtl/alu_share_arbiter.sv | 125 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// The result is captured in a single response holding register with 1-cycle latency.
module alu_share_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,

    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_zero,

    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_zero,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              rr_pri_q, rr_pri_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;

    logic              owner_rdy;
    logic              slot_free;
    logic              gnt_vld;
    logic              gnt_id;

    // Grant: the slot may be refilled in the same cycle its owner drains it.
    always_comb begin
        owner_rdy = owner_q ? rsp1_ready : rsp0_ready;
        slot_free = (state_q == EMPTY) || owner_rdy;
        gnt_vld   = slot_free && (req0_valid || req1_valid);
        gnt_id    = (req0_valid && req1_valid) ? rr_pri_q : req1_valid;
    end

    // Ready is gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        req0_ready = rst_n && gnt_vld && !gnt_id;
        req1_ready = rst_n && gnt_vld && gnt_id;
    end

    // Requester 0's operands are the idle default to keep the ALU inputs quiet.
    always_comb begin
        if (gnt_vld && gnt_id) begin
            alu_a  = req1_a;
            alu_b  = req1_b;
            alu_op = req1_op;
        end else begin
            alu_a  = req0_a;
            alu_b  = req0_b;
            alu_op = req0_op;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_pri_d = rr_pri_q;
        result_d = result_q;
        zero_d   = zero_q;
        if (gnt_vld) begin
            state_d  = FULL;
            owner_d  = gnt_id;
            result_d = alu_result;
            zero_d   = alu_zero;
            rr_pri_d = !gnt_id;
        end else if ((state_q == FULL) && owner_rdy) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            owner_q  <= 1'b0;
            rr_pri_q <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_pri_q <= rr_pri_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    // Both response channels view the same holding register; valid selects the owner.
    always_comb begin
        rsp0_valid  = (state_q == FULL) && !owner_q;
        rsp1_valid  = (state_q == FULL) && owner_q;
        rsp0_result = result_q;
        rsp1_result = result_q;
        rsp0_zero   = zero_q;
        rsp1_zero   = zero_q;
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed test-plan cases plus randomized
// traffic checked against a transaction-level model of the arbiter.
module tb_alu_share_arbiter;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;

    logic              clk;
    logic              rst_n;
    logic              req0_valid, req0_ready, req1_valid, req1_ready;
    logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [OP_W-1:0]   req0_op, req1_op;
    logic              rsp0_valid, rsp0_ready, rsp0_zero;
    logic              rsp1_valid, rsp1_ready, rsp1_zero;
    logic [DATA_W-1:0] rsp0_result, rsp1_result;
    logic [DATA_W-1:0] alu_a, alu_b, alu_result;
    logic [OP_W-1:0]   alu_op;
    logic              alu_zero;

    int n_chk;
    int n_fail;

    // Model state: one outstanding response plus the round-robin pointer.
    logic              m_full;
    logic              m_owner;
    logic              m_rr;
    logic [DATA_W-1:0] m_res;
    logic              m_zero;
    logic              last_g0, last_g1;

    alu_share_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_result(rsp0_result),
        .rsp0_zero  (rsp0_zero),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_result(rsp1_result),
        .rsp1_zero  (rsp1_zero),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero)
    );

    function automatic logic [DATA_W-1:0] alu_fn(logic [DATA_W-1:0] a, logic [DATA_W-1:0] b,
                                                 logic [OP_W-1:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return DATA_W'($signed(a) >>> b[4:0]);
            4'd8:    return DATA_W'($signed(a) < $signed(b));
            4'd9:    return DATA_W'(a < b);
            default: return '0;
        endcase
    endfunction

    // External ALU stand-in.
    always_comb begin
        alu_result = alu_fn(alu_a, alu_b, alu_op);
        alu_zero   = (alu_result == '0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_full  = 1'b0;
        m_owner = 1'b0;
        m_rr    = 1'b0;
        m_res   = '0;
        m_zero  = 1'b0;
        last_g0 = 1'b0;
        last_g1 = 1'b0;
    endtask

    task automatic set_req(input int n, input logic v, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op);
        if (n == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end
    endtask

    // One clock cycle: called at a falling edge with inputs set, returns at the next falling edge.
    task automatic tick();
        logic sf, g_vld, g_id;
        logic [DATA_W-1:0] ga, gb;
        logic [OP_W-1:0] gop;
        #1;
        sf    = !m_full || (m_owner ? rsp1_ready : rsp0_ready);
        g_vld = sf && (req0_valid || req1_valid);
        if (req0_valid && req1_valid) g_id = m_rr;
        else                          g_id = req1_valid;
        check_eq("req0_ready", 32'(req0_ready), 32'(g_vld && !g_id));
        check_eq("req1_ready", 32'(req1_ready), 32'(g_vld && g_id));
        check_eq("rsp0_valid", 32'(rsp0_valid), 32'(m_full && !m_owner));
        check_eq("rsp1_valid", 32'(rsp1_valid), 32'(m_full && m_owner));
        if (m_full && !m_owner) begin
            check_eq("rsp0_result", rsp0_result, m_res);
            check_eq("rsp0_zero", 32'(rsp0_zero), 32'(m_zero));
        end
        if (m_full && m_owner) begin
            check_eq("rsp1_result", rsp1_result, m_res);
            check_eq("rsp1_zero", 32'(rsp1_zero), 32'(m_zero));
        end
        ga  = g_id ? req1_a : req0_a;
        gb  = g_id ? req1_b : req0_b;
        gop = g_id ? req1_op : req0_op;
        @(posedge clk);
        last_g0 = g_vld && !g_id;
        last_g1 = g_vld && g_id;
        if (g_vld) begin
            m_full  = 1'b1;
            m_owner = g_id;
            m_res   = alu_fn(ga, gb, gop);
            m_zero  = (m_res == '0);
            m_rr    = !g_id;
        end else if (sf) begin
            m_full = 1'b0;
        end
        @(negedge clk);
    endtask

    logic [31:0] ra, rb;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        model_reset();
        rst_n      = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        set_req(0, 1'b1, 32'd1, 32'd2, 4'd0);
        set_req(1, 1'b1, 32'd3, 32'd4, 4'd0);

        // Reset state, with requests presented while reset is held.
        #12;
        check_eq("rst_req0_ready", 32'(req0_ready), 32'd0);
        check_eq("rst_req1_ready", 32'(req1_ready), 32'd0);
        check_eq("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        check_eq("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        check_eq("rst_result", rsp0_result, 32'd0);
        check_eq("rst_zero", 32'(rsp0_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
        tick();

        // Single requester SUB 5-3.
        set_req(0, 1'b1, 32'd5, 32'd3, 4'd1);
        tick();
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        check_eq("sub_valid", 32'(rsp0_valid), 32'd1);
        check_eq("sub_result", rsp0_result, 32'd2);
        check_eq("sub_zero", 32'(rsp0_zero), 32'd0);
        tick();

        // Backpressure: requester 0 owns the slot and stalls, requester 1 waits.
        set_req(0, 1'b1, 32'd7, 32'd9, 4'd3);
        rsp0_ready = 1'b0;
        tick();
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        set_req(1, 1'b1, 32'd10, 32'd4, 4'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("bp_hold_result", rsp0_result, 32'd15);
            check_eq("bp_hold_valid", 32'(rsp0_valid), 32'd1);
        end
        rsp0_ready = 1'b1;
        tick();
        check_eq("bp_r1_granted", 32'(last_g1), 32'd1);
        set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
        check_eq("bp_rsp1_valid", 32'(rsp1_valid), 32'd1);
        check_eq("bp_rsp1_result", rsp1_result, 32'd14);
        tick();

        // Shifts, compares and an unused op code.
        set_req(0, 1'b1, 32'h8000_0000, 32'd4, 4'd7);
        tick();
        check_eq("sra_result", rsp0_result, 32'hF800_0000);
        set_req(0, 1'b1, 32'hFFFF_FFFF, 32'd1, 4'd8);
        tick();
        check_eq("slt_result", rsp0_result, 32'd1);
        set_req(0, 1'b1, 32'hFFFF_FFFF, 32'd1, 4'd9);
        tick();
        check_eq("sltu_result", rsp0_result, 32'd0);
        check_eq("sltu_zero", 32'(rsp0_zero), 32'd1);
        set_req(0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 4'd12);
        tick();
        check_eq("op12_valid", 32'(rsp0_valid), 32'd1);
        check_eq("op12_result", rsp0_result, 32'd0);
        check_eq("op12_zero", 32'(rsp0_zero), 32'd1);
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        tick();

        // Reset mid-operation with requester 1 holding a response.
        set_req(1, 1'b1, 32'd6, 32'd6, 4'd4);
        rsp1_ready = 1'b0;
        tick();
        check_eq("mid_rsp1_valid", 32'(rsp1_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rsp1_valid", 32'(rsp1_valid), 32'd0);
        check_eq("async_req1_ready", 32'(req1_ready), 32'd0);
        check_eq("async_result", rsp1_result, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n      = 1'b1;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;

        // Contention straight after reset: grants alternate starting at requester 0.
        set_req(0, 1'b1, 32'd1, 32'd1, 4'd0);
        set_req(1, 1'b1, 32'hF0, 32'h0F, 4'd2);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("cont_g0", 32'(last_g0), 32'((i % 2) == 0));
            check_eq("cont_g1", 32'(last_g1), 32'((i % 2) == 1));
            if ((i % 2) == 0) check_eq("cont_rsp0_result", rsp0_result, 32'd2);
            else begin
                check_eq("cont_rsp1_result", rsp1_result, 32'd0);
                check_eq("cont_rsp1_zero", 32'(rsp1_zero), 32'd1);
            end
        end

        // Randomized traffic, honouring the hold-until-ready contract.
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
        last_g0 = 1'b0;
        last_g1 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!req0_valid || last_g0) begin
                ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
                rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
                set_req(0, 1'($urandom_range(0, 2) != 0), ra, rb, 4'($urandom_range(0, 15)));
            end
            if (!req1_valid || last_g1) begin
                ra = $urandom;
                rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
                set_req(1, 1'($urandom_range(0, 2) != 0), ra, rb, 4'($urandom_range(0, 15)));
            end
            rsp0_ready = ($urandom_range(0, 9) < 7);
            rsp1_ready = ($urandom_range(0, 9) < 7);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
